key_debounce_multi: RTL

Parametrised multi-channel push-button conditioner for active-low mechanical keys, sitting between the board key pins and the VIP control logic (mode selection, menu and threshold adjust). Each channel gets a 2-FF synchroniser and a symmetric press/release debouncer. It produces a debounced level plus single-cycle press, release, long-press and auto-repeat strobes. A shared millisecond prescaler times the hold behaviour for all channels.

---
 rtl/key_debounce_multi.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_multi.sv
// Purpose : multi-channel active-low push-button conditioner (sync + debounce + press/release/long/repeat strobes).
// Latency : key_level follows a stable key_in at the (CNT_MAX+2)th edge; all strobes are registered.
// Backpr. : none; free-running, every output is a level or a single-cycle strobe with no handshake.
//
// Ports:
//   sys_clk       system clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   key_in        raw key pins, 0 = pressed, asynchronous to sys_clk
//   key_level     debounced key state, 1 = pressed
//   press_flag    1-cycle strobe in the first cycle key_level shows a press
//   release_flag  1-cycle strobe in the first cycle key_level shows a release
//   long_flag     1-cycle strobe when the hold reaches LONG_MS ticks
//   repeat_flag   1-cycle strobe every REPEAT_MS ticks after long_flag while held
module key_debounce_multi #(
  parameter int KEY_NUM   = 4,
  parameter int CNT_MAX   = 999_999,
  parameter int CNT_W     = 20,
  parameter int TICK_MAX  = 49_999,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] press_flag,
  output logic [KEY_NUM-1:0] release_flag,
  output logic [KEY_NUM-1:0] long_flag,
  output logic [KEY_NUM-1:0] repeat_flag
);

  localparam int TICK_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int LONG_W = $clog2(LONG_MS + 1);
  localparam int REP_W  = $clog2(REPEAT_MS + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_MS);

  typedef enum logic [1:0] {ST_REL, ST_PRS, ST_HOLD} state_t;

  // Two-stage synchroniser; idles at 1 (released) so reset never looks like a press.
  logic [KEY_NUM-1:0] sync_s1;
  logic [KEY_NUM-1:0] sync_s2;
  logic [KEY_NUM-1:0] key_sync;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_s1 <= '1;
      sync_s2 <= '1;
    end else begin
      sync_s1 <= key_in;
      sync_s2 <= sync_s1;
    end
  end

  assign key_sync = ~sync_s2;

  // Shared hold-time prescaler; not aligned to key events.
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    logic [CNT_W-1:0]  db_cnt;
    logic              lvl_q;
    logic              db_hit;
    logic              lvl_rise;
    logic              lvl_fall;
    state_t            state;
    logic [LONG_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [LONG_W-1:0] hold_nxt;
    logic [REP_W-1:0]  rep_nxt;
    logic              press_q;
    logic              rel_q;
    logic              long_q;
    logic              rep_q;

    // db_hit marks the edge on which key_level toggles; the FSM keys off it so
    // press/release strobes line up with the first cycle of the new level.
    assign db_hit   = (key_sync[i] != lvl_q) && (db_cnt == CNT_LAST);
    assign lvl_rise = db_hit & ~lvl_q;
    assign lvl_fall = db_hit &  lvl_q;
    assign hold_nxt = hold_cnt + LONG_W'(1);
    assign rep_nxt  = rep_cnt + REP_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        db_cnt <= '0;
        lvl_q  <= 1'b0;
      end else if (key_sync[i] == lvl_q) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        db_cnt <= '0;
        lvl_q  <= ~lvl_q;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        state    <= ST_REL;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
        case (state)
          ST_REL: begin
            if (lvl_rise) begin
              press_q  <= 1'b1;
              hold_cnt <= '0;
              state    <= ST_PRS;
            end
          end
          ST_PRS: begin
            // Release wins over a coincident tick.
            if (lvl_fall) begin
              rel_q    <= 1'b1;
              hold_cnt <= '0;
              rep_cnt  <= '0;
              state    <= ST_REL;
            end else if (tick) begin
              hold_cnt <= hold_nxt;
              if (hold_nxt == LONG_LAST) begin
                long_q  <= 1'b1;
                rep_cnt <= '0;
                state   <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (lvl_fall) begin
              rel_q    <= 1'b1;
              hold_cnt <= '0;
              rep_cnt  <= '0;
              state    <= ST_REL;
            end else if (tick) begin
              if (rep_nxt == REP_LAST) begin
                rep_q   <= REPEAT_EN;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_nxt;
              end
            end
          end
          default: state <= ST_REL;
        endcase
      end
    end

    assign key_level[i]    = lvl_q;
    assign press_flag[i]   = press_q;
    assign release_flag[i] = rel_q;
    assign long_flag[i]    = long_q;
    assign repeat_flag[i]  = rep_q;
  end

endmodule
